vga_fb_fetch: RTL

Framebuffer fetch scheduler for the 1-bit VGA pipeline. Configured over an Avalon-MM slave, it reads a frame of 16-bit pixel words from memory through an Avalon-MM read master. It pushes those words into the write side of the pixel dual-clock FIFO and throttles on FIFO fill level. It signals frame completion via a sticky status bit and an optional interrupt; the display side of the FIFO is outside this block.

---
 rtl/vga_fb_fetch.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vga_fb_fetch.sv
// Framebuffer fetch scheduler: reads a frame of 16-bit words over Avalon-MM and pushes them into the pixel FIFO.
// Optional feature macro: VGA_FB_IRQ_EN (implements CTRL.IRQ_EN and the frame-done interrupt).
module vga_fb_fetch #(
    parameter int FIFO_AW    = 12,
    parameter int HIGH_WATER = 4000,
    parameter int LEN_W      = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               avs_s1_chipselect,
    input  logic               avs_s1_read,
    input  logic               avs_s1_write,
    input  logic [2:0]         avs_s1_address,
    input  logic [31:0]        avs_s1_writedata,
    input  logic [3:0]         avs_s1_byteenable,
    output logic [31:0]        avs_s1_readdata,
    output logic               avs_s1_waitrequest,
    output logic               avs_s1_irq,
    output logic [31:0]        avm_read_address,
    output logic               avm_read_read,
    input  logic [15:0]        avm_read_readdata,
    input  logic               avm_read_waitrequest,
    output logic               fifo_write_write,
    output logic [15:0]        fifo_write_writedata,
    input  logic               fifo_write_waitrequest,
    input  logic [FIFO_AW-1:0] fifo_wruserdw
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_PUSH, S_EOF} state_t;

    localparam logic [FIFO_AW-1:0] HW_LEVEL = FIFO_AW'(HIGH_WATER);

    state_t            state, state_nxt;
    logic              run, cont, irq_en, done;
    logic [31:0]       base;
    logic [LEN_W-1:0]  len;
    logic [15:0]       frames;
    logic [31:0]       addr;
    logic [LEN_W-1:0]  cnt;
    logic [15:0]       data;
    logic              reg_wr, ctrl_wr, run_req, start, reload;
    logic              unused_ok;

    assign unused_ok          = &{1'b0, avs_s1_byteenable};
    assign avs_s1_waitrequest = 1'b0;

    assign reg_wr  = avs_s1_chipselect & avs_s1_write;
    assign ctrl_wr = reg_wr && (avs_s1_address == 3'd0);
    // Idle start looks at the RUN write in flight so CHECK is reached the cycle after the write.
    assign run_req = ctrl_wr ? avs_s1_writedata[0] : run;
    assign start   = (state == S_IDLE) && run_req && (len != '0);
    assign reload  = cont && run && (len != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run    <= 1'b0;
            cont   <= 1'b0;
            base   <= '0;
            len    <= '0;
            done   <= 1'b0;
            frames <= '0;
        end else begin
            if (state == S_EOF && !reload)
                run <= 1'b0;
            if (reg_wr) begin
                case (avs_s1_address)
                    3'd0: begin
                        run  <= avs_s1_writedata[0];
                        cont <= avs_s1_writedata[2];
                    end
                    3'd1:    base <= {avs_s1_writedata[31:1], 1'b0};
                    3'd2:    len  <= avs_s1_writedata[LEN_W-1:0];
                    default: ;
                endcase
            end
            // Frame-end set is ordered after the host clear so it wins on collision.
            if (reg_wr && avs_s1_address == 3'd3 && avs_s1_writedata[1])
                done <= 1'b0;
            if (state == S_EOF) begin
                done   <= 1'b1;
                frames <= frames + 16'd1;
            end
        end
    end

`ifdef VGA_FB_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (ctrl_wr)
                irq_en <= avs_s1_writedata[1];
            irq_q <= done & irq_en;
        end
    end

    assign avs_s1_irq = irq_q;
`else
    assign irq_en     = 1'b0;
    assign avs_s1_irq = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (start)
                    state_nxt = S_CHECK;
            S_CHECK:
                if (!run)
                    state_nxt = S_IDLE;
                else if (fifo_wruserdw < HW_LEVEL)
                    state_nxt = S_READ;
            // A read in flight must finish; if RUN dropped meanwhile the word is dropped.
            S_READ:
                if (!avm_read_waitrequest)
                    state_nxt = run ? S_PUSH : S_IDLE;
            S_PUSH:
                if (!run)
                    state_nxt = S_IDLE;
                else if (!fifo_write_waitrequest)
                    state_nxt = (cnt == '0) ? S_EOF : S_CHECK;
            S_EOF:
                state_nxt = reload ? S_CHECK : S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        avm_read_read    = 1'b0;
        fifo_write_write = 1'b0;
        case (state)
            S_READ:  avm_read_read    = 1'b1;
            S_PUSH:  fifo_write_write = run;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr <= '0;
            cnt  <= '0;
            data <= '0;
        end else if (start || (state == S_EOF && reload)) begin
            addr <= base;
            cnt  <= len;
        end else if (state == S_READ && !avm_read_waitrequest) begin
            data <= avm_read_readdata;
            addr <= addr + 32'd2;
            cnt  <= cnt - LEN_W'(1);
        end
    end

    assign avm_read_address     = addr;
    assign fifo_write_writedata = data;

    always_comb begin
        avs_s1_readdata = '0;
        if (avs_s1_chipselect && avs_s1_read) begin
            case (avs_s1_address)
                3'd0:    avs_s1_readdata = {29'd0, cont, irq_en, run};
                3'd1:    avs_s1_readdata = base;
                3'd2:    avs_s1_readdata = 32'(len);
                3'd3:    avs_s1_readdata = {30'd0, done, state != S_IDLE};
                3'd4:    avs_s1_readdata = {16'd0, frames};
                default: avs_s1_readdata = '0;
            endcase
        end
    end

endmodule
